// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encodings, exception flag bit
// positions, converter FSM state encodings, operand classes and the IEEE
// exponent bias helper.
package fpu_pkg;

    // Rounding modes
    localparam logic [1:0] RM_RTZ = 2'b00;
    localparam logic [1:0] RM_RUP = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RNE = 2'b11;

    // Exception flag vector {invalid, overflow, underflow, inexact, reserved}
    localparam int unsigned FLAG_W         = 5;
    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_OVERFLOW  = 3;
    localparam int unsigned FLAG_UNDERFLOW = 2;
    localparam int unsigned FLAG_INEXACT   = 1;
    localparam int unsigned FLAG_RSVD      = 0;

    // Converter FSM states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLASSIFY = 2'd1;
    localparam logic [1:0] ST_ROUND    = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

    // Operand classes
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_t;

    // IEEE-754 exponent bias for an exponent field of exp_w bits
    function automatic int bias(input int unsigned exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision shared by FPU blocks.
// Ports: sign - result sign; lsb - retained significand LSB; g - guard bit;
//        s - sticky bit; rm - rounding mode; inc - add one ulp to significand.
module fp_round_inc
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    input  logic [1:0] rm,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & (g | s);
            RM_RDN:  inc = sign & (g | s);
            default: inc = g & (s | lsb);   // nearest-even: ties go to even lsb
        endcase
    end

endmodule

// File: rtl/fp_narrow_convert.sv
// IEEE-754 narrowing converter (default binary64 -> binary32).
// One operand in flight: IDLE -> CLASSIFY -> ROUND (align, then round/pack)
// -> HOLD. out_valid rises three edges after the accept edge.
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_data/in_rm
//        operand handshake; out_valid/out_ready/out_data/out_flags result
//        handshake, flags = {invalid, overflow, underflow, inexact, 0}.
module fp_narrow_convert
    import fpu_pkg::*;
#(
    parameter int unsigned SRC_EXP = 11,
    parameter int unsigned SRC_MAN = 52,
    parameter int unsigned DST_EXP = 8,
    parameter int unsigned DST_MAN = 23
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SRC_EXP+SRC_MAN:0]   in_data,
    input  logic [1:0]                 in_rm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DST_EXP+DST_MAN:0]   out_data,
    output logic [FLAG_W-1:0]          out_flags
);

    localparam int unsigned OUT_W = 1 + DST_EXP + DST_MAN;
    localparam int unsigned EW    = SRC_EXP + 2;             // signed rebiased exponent
    localparam int unsigned SIGW  = DST_MAN + 1;             // hidden bit + fraction
    localparam int unsigned XW    = SRC_MAN + DST_MAN + 3;   // alignment window
    localparam int unsigned SHMAX = DST_MAN + 2;
    localparam int unsigned SHW   = $clog2(SHMAX + 1);

    localparam logic signed [EW-1:0] BIAS_DIFF    = EW'(bias(DST_EXP) - bias(SRC_EXP));
    localparam logic signed [EW-1:0] EXP_ALL_ONES = EW'((1 << DST_EXP) - 1);
    localparam logic signed [EW-1:0] SH_LIMIT     = EW'(SHMAX);
    localparam logic [DST_EXP-1:0]   EXP_ONES_FLD = {DST_EXP{1'b1}};
    localparam logic [DST_EXP-1:0]   EXP_MAX_FLD  = {{(DST_EXP-1){1'b1}}, 1'b0};

    // FSM
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       round_phase;

    // Captured operand
    logic               sign_q;
    logic [SRC_EXP-1:0] exp_q;
    logic [SRC_MAN-1:0] man_q;
    logic [1:0]         rm_q;

    // Classification results
    fp_class_t          cls_c;
    fp_class_t          cls_q;
    logic signed [EW-1:0] e_rb_c;
    logic signed [EW-1:0] e_q;

    // Alignment results
    logic signed [EW-1:0] sh_amt_c;
    logic [SHW-1:0]       sh_c;
    logic [XW-1:0]        x_full_c;
    logic [XW-1:0]        x_sh_c;
    logic [SIGW-1:0]      sig_c;
    logic                 g_c;
    logic                 s_c;
    logic                 tiny_c;
    logic [SIGW-1:0]      sig_q;
    logic                 g_q;
    logic                 s_q;
    logic                 tiny_q;

    // Round and pack
    logic                 inc_c;
    logic [SIGW:0]        sig_inc_c;
    logic [DST_MAN-1:0]   frac_c;
    logic signed [EW-1:0] e_post_c;
    logic [DST_EXP-1:0]   exp_fld_c;
    logic                 ovf_c;
    logic                 inexact_c;
    logic                 to_max_c;
    logic [OUT_W-1:0]     data_c;
    logic [FLAG_W-1:0]    flags_c;

    logic accept;
    assign accept = (state == ST_IDLE) && in_valid && in_ready;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (in_valid && in_ready) state_nxt = ST_CLASSIFY;
            ST_CLASSIFY: state_nxt = ST_ROUND;
            ST_ROUND:    if (round_phase) state_nxt = ST_HOLD;
            ST_HOLD:     if (out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State register and handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            round_phase <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            round_phase <= (state == ST_ROUND) && !round_phase;
            in_ready    <= (state_nxt == ST_IDLE);
            out_valid   <= (state_nxt == ST_HOLD);
        end
    end

    // Operand capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            man_q  <= '0;
            rm_q   <= RM_RTZ;
        end else if (accept) begin
            sign_q <= in_data[SRC_EXP+SRC_MAN];
            exp_q  <= in_data[SRC_EXP+SRC_MAN-1:SRC_MAN];
            man_q  <= in_data[SRC_MAN-1:0];
            rm_q   <= in_rm;
        end
    end

    // Class decode and exponent rebias
    always_comb begin
        cls_c = CLS_NORM;
        if (exp_q == '0) begin
            cls_c = (man_q == '0) ? CLS_ZERO : CLS_SUB;
        end else if (&exp_q) begin
            if (man_q == '0)           cls_c = CLS_INF;
            else if (man_q[SRC_MAN-1]) cls_c = CLS_QNAN;
            else                       cls_c = CLS_SNAN;
        end
        e_rb_c = $signed({2'b00, exp_q}) + BIAS_DIFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_q <= CLS_ZERO;
            e_q   <= '0;
        end else if (state == ST_CLASSIFY) begin
            cls_q <= cls_c;
            e_q   <= e_rb_c;
        end
    end

    // Alignment: tiny results shift right by 1-e; shifts past SHMAX park the
    // hidden bit below guard so it still lands in sticky.
    always_comb begin
        sh_amt_c = $signed(EW'(1)) - e_q;
        if (e_q > 0)                sh_c = '0;
        else if (sh_amt_c > SH_LIMIT) sh_c = SHW'(SHMAX);
        else                        sh_c = SHW'(sh_amt_c);

        x_full_c = {1'b1, man_q, {(DST_MAN+2){1'b0}}};
        x_sh_c   = x_full_c >> sh_c;

        sig_c  = '0;
        g_c    = 1'b0;
        s_c    = 1'b0;
        tiny_c = 1'b0;
        case (cls_q)
            CLS_NORM: begin
                sig_c  = x_sh_c[XW-1 -: SIGW];
                g_c    = x_sh_c[XW-1-SIGW];
                s_c    = |x_sh_c[XW-2-SIGW:0];
                tiny_c = (e_q <= 0);
            end
            CLS_SUB: begin
                // Far below the destination range: only sticky survives.
                s_c    = 1'b1;
                tiny_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q  <= '0;
            g_q    <= 1'b0;
            s_q    <= 1'b0;
            tiny_q <= 1'b0;
        end else if ((state == ST_ROUND) && !round_phase) begin
            sig_q  <= sig_c;
            g_q    <= g_c;
            s_q    <= s_c;
            tiny_q <= tiny_c;
        end
    end

    fp_round_inc u_round_inc (
        .sign (sign_q),
        .lsb  (sig_q[0]),
        .g    (g_q),
        .s    (s_q),
        .rm   (rm_q),
        .inc  (inc_c)
    );

    // Increment, renormalise, overflow detect and result assembly
    always_comb begin
        sig_inc_c = {1'b0, sig_q} + (SIGW+1)'(inc_c);
        frac_c    = sig_inc_c[DST_MAN-1:0];
        e_post_c  = e_q;
        exp_fld_c = '0;
        ovf_c     = 1'b0;
        if (tiny_q) begin
            // Carry into the hidden bit promotes to the minimum normal.
            exp_fld_c = sig_inc_c[DST_MAN] ? DST_EXP'(1) : '0;
        end else begin
            if (sig_inc_c[SIGW]) begin
                frac_c   = sig_inc_c[SIGW-1:1];
                e_post_c = e_q + $signed(EW'(1));
            end
            ovf_c     = (e_post_c >= EXP_ALL_ONES);
            exp_fld_c = DST_EXP'(e_post_c);
        end

        inexact_c = g_q | s_q;
        to_max_c  = (rm_q == RM_RTZ) || ((rm_q == RM_RUP) && sign_q) ||
                    ((rm_q == RM_RDN) && !sign_q);

        data_c  = '0;
        flags_c = '0;
        case (cls_q)
            CLS_ZERO: data_c = {sign_q, {DST_EXP{1'b0}}, {DST_MAN{1'b0}}};
            CLS_INF:  data_c = {sign_q, EXP_ONES_FLD, {DST_MAN{1'b0}}};
            CLS_QNAN: data_c = {sign_q, EXP_ONES_FLD, man_q[SRC_MAN-1 -: DST_MAN]};
            CLS_SNAN: begin
                data_c = {sign_q, EXP_ONES_FLD, 1'b1, man_q[SRC_MAN-2 -: DST_MAN-1]};
                flags_c[FLAG_INVALID] = 1'b1;
            end
            default: begin
                if (ovf_c) begin
                    data_c = to_max_c ? {sign_q, EXP_MAX_FLD, {DST_MAN{1'b1}}}
                                      : {sign_q, EXP_ONES_FLD, {DST_MAN{1'b0}}};
                    flags_c[FLAG_OVERFLOW] = 1'b1;
                    flags_c[FLAG_INEXACT]  = 1'b1;
                end else begin
                    data_c = {sign_q, exp_fld_c, frac_c};
                    flags_c[FLAG_UNDERFLOW] = tiny_q & inexact_c;
                    flags_c[FLAG_INEXACT]   = inexact_c;
                end
            end
        endcase
        flags_c[FLAG_RSVD] = 1'b0;
    end

    // Result register, held through HOLD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_flags <= '0;
        end else if ((state == ST_ROUND) && round_phase) begin
            out_data  <= data_c;
            out_flags <= flags_c;
        end
    end

endmodule

// File: tb/tb_fp_narrow_convert.sv
// Directed, table-driven bench for fp_narrow_convert (binary64 -> binary32).
// Checks results, flags, fixed latency, back-pressure hold and reset abort.
module tb_fp_narrow_convert;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_narrow_convert dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rm     (in_rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] din;
        logic [1:0]  rm;
        logic [31:0] dout;
        logic [4:0]  flags;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one operand, check the 3-edge latency, take the result.
    task automatic run_op(input logic [63:0] d, input logic [1:0] rm, input string name,
                          output logic [31:0] res, output logic [4:0] fl);
        int waitc = 0;
        while (!in_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        check({name, " ready"}, 64'(in_ready), 64'(1));
        in_data  = d;
        in_rm    = rm;
        in_valid = 1'b1;
        tick();                      // accept edge
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("%s latency@%0d", name, k), 64'(out_valid), 64'(k == 3));
        end
        res = out_data;
        fl  = out_flags;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " released"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  fl;
        logic [31:0] held;

        // {din, rm, expected data, expected flags {inv,ovf,unf,inx,0}}
        vecs.push_back('{64'h3FF0000000000000, 2'b00, 32'h3F800000, 5'h00});
        vecs.push_back('{64'h3FF0000000000000, 2'b01, 32'h3F800000, 5'h00});
        vecs.push_back('{64'h3FF0000000000000, 2'b10, 32'h3F800000, 5'h00});
        vecs.push_back('{64'h3FF0000000000000, 2'b11, 32'h3F800000, 5'h00});
        vecs.push_back('{64'h3FF0000010000000, 2'b11, 32'h3F800000, 5'h02});
        vecs.push_back('{64'h3FF0000010000000, 2'b01, 32'h3F800001, 5'h02});
        vecs.push_back('{64'h3FF0000010000000, 2'b10, 32'h3F800000, 5'h02});
        vecs.push_back('{64'h47F0000000000000, 2'b11, 32'h7F800000, 5'h0A});
        vecs.push_back('{64'h47F0000000000000, 2'b00, 32'h7F7FFFFF, 5'h0A});
        vecs.push_back('{64'hC7F0000000000000, 2'b01, 32'hFF7FFFFF, 5'h0A});
        vecs.push_back('{64'h7FF4000000000000, 2'b11, 32'h7FE00000, 5'h10});
        vecs.push_back('{64'h7FF8000000000000, 2'b11, 32'h7FC00000, 5'h00});
        vecs.push_back('{64'h36A0000000000000, 2'b11, 32'h00000001, 5'h00});
        vecs.push_back('{64'h3690000000000000, 2'b11, 32'h00000000, 5'h06});
        vecs.push_back('{64'h3690000000000000, 2'b01, 32'h00000001, 5'h06});
        vecs.push_back('{64'h8000000000000000, 2'b11, 32'h80000000, 5'h00});
        vecs.push_back('{64'hFFF0000000000000, 2'b00, 32'hFF800000, 5'h00});
        vecs.push_back('{64'h0000000000000001, 2'b01, 32'h00000001, 5'h06});
        vecs.push_back('{64'h0000000000000001, 2'b11, 32'h00000000, 5'h06});
        vecs.push_back('{64'h8000000000000001, 2'b10, 32'h80000001, 5'h06});
        vecs.push_back('{64'h3FFFFFFFF0000000, 2'b11, 32'h40000000, 5'h02});
        vecs.push_back('{64'h47EFFFFFF0000000, 2'b11, 32'h7F800000, 5'h0A});
        vecs.push_back('{64'h380FFFFFF0000000, 2'b11, 32'h00800000, 5'h06});
        vecs.push_back('{64'h3800000000000000, 2'b11, 32'h00400000, 5'h00});

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rm     = 2'b00;
        out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst out_data",  64'(out_data),  64'(0));
        check("rst out_flags", 64'(out_flags), 64'(0));
        check("rst in_ready",  64'(in_ready),  64'(0));
        reset = 1'b1;
        check("release in_ready before edge", 64'(in_ready), 64'(0));
        tick();
        check("release in_ready after edge", 64'(in_ready), 64'(1));

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].din, vecs[i].rm, $sformatf("vec%0d", i), res, fl);
            check($sformatf("vec%0d data", i),  64'(res), 64'(vecs[i].dout));
            check($sformatf("vec%0d flags", i), 64'(fl),  64'(vecs[i].flags));
        end

        // Back-pressure: result held for 5 cycles with out_ready low
        in_data  = 64'h3FF0000010000000;
        in_rm    = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("bp valid", 64'(out_valid), 64'(1));
        held = out_data;
        check("bp data", 64'(held), 64'(32'h3F800001));
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp hold valid %0d", k), 64'(out_valid), 64'(1));
            check($sformatf("bp hold data %0d", k),  64'(out_data),  64'(32'h3F800001));
            check($sformatf("bp hold flags %0d", k), 64'(out_flags), 64'(5'h02));
            check($sformatf("bp hold in_ready %0d", k), 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp taken valid", 64'(out_valid), 64'(0));
        check("bp taken in_ready", 64'(in_ready), 64'(1));

        // Reset during ROUND aborts the operand
        in_data  = 64'h3FF0000000000000;
        in_rm    = 2'b11;
        in_valid = 1'b1;
        tick();                      // accept -> CLASSIFY
        in_valid = 1'b0;
        tick();                      // -> ROUND
        reset = 1'b0;
        #1;
        check("abort valid in reset", 64'(out_valid), 64'(0));
        check("abort in_ready in reset", 64'(in_ready), 64'(0));
        tick();
        reset = 1'b1;
        tick();
        check("abort in_ready after release", 64'(in_ready), 64'(1));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("abort no valid %0d", k), 64'(out_valid), 64'(0));
            tick();
        end

        // Converter still works after the abort
        run_op(64'hBFF0000000000000, 2'b00, "post-abort", res, fl);
        check("post-abort data",  64'(res), 64'(32'hBF800000));
        check("post-abort flags", 64'(fl),  64'(5'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_narrow_convert.md
FP_NARROW_CONVERT -- requirements
Module: fp_narrow_convert

Interface
REQ-001 SHALL have parameter SRC_EXP, default 11: source exponent width.
REQ-002 SHALL have parameter SRC_MAN, default 52: source fraction width.
REQ-003 SHALL have parameter DST_EXP, default 8: destination exponent width, < SRC_EXP.
REQ-004 SHALL have parameter DST_MAN, default 23: destination fraction width, < SRC_MAN.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: operand present.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-009 SHALL have port in_data, input, 1+SRC_EXP+SRC_MAN bits: source IEEE-754 value.
REQ-010 SHALL have port in_rm, input, 2 bits: rounding mode; 00 toward zero, 01 toward +inf, 10 toward -inf, 11 nearest-even.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port out_data, output, 1+DST_EXP+DST_MAN bits: converted value.
REQ-014 SHALL have port out_flags, output, 5 bits: {invalid, overflow, underflow, inexact, reserved=0}.

Function
REQ-015 SHALL use FSM IDLE -> CLASSIFY -> ROUND -> HOLD -> IDLE.
REQ-016 SHALL assert in_ready only in IDLE; in_valid&in_ready SHALL capture in_data and in_rm and go to CLASSIFY.
REQ-017 SHALL, in CLASSIFY, decode class: zero, source subnormal, normal, inf, qNaN, sNaN; it SHALL rebias the exponent as e_src - bias_src + bias_dst in a signed (SRC_EXP+2)-bit field.
REQ-018 SHALL, in ROUND, form the 1+DST_MAN significand plus guard, round and sticky (sticky = OR of all discarded bits); it SHALL right-shift by (1 - e_dst) for e_dst <= 0, saturating the shift at DST_MAN+2 with every bit folded into sticky.
REQ-019 SHALL apply rounding: RTZ never increments; +inf increments if positive and (g|s); -inf increments if negative and (g|s); RNE increments if g&(s|lsb).
REQ-020 SHALL, on significand carry-out, shift right by 1 and increment the exponent; a subnormal carrying into the hidden bit SHALL become the minimum normal.
REQ-021 SHALL handle overflow (post-round exponent >= all-ones): in RTZ, or in a directed mode toward zero, return max finite; otherwise return inf; it SHALL set overflow and inexact.
REQ-022 SHALL set underflow when the result is tiny (pre-round e_dst <= 0) and inexact; an exact subnormal SHALL raise no flag.
REQ-023 SHALL propagate sign unchanged for all classes, including zero and NaN.
REQ-024 SHALL map inf to inf with no flags.
REQ-025 SHALL map a qNaN to a NaN using the top DST_MAN fraction bits, with no flags.
REQ-026 SHALL map an sNaN to a NaN using the same fraction bits with the MSB forced to 1 (quieted), and SHALL set invalid.
REQ-027 SHALL treat a source subnormal as a nonzero tiny value: the result is zero, or the minimum subnormal when a directed mode rounds away from zero; it SHALL set underflow and inexact.
REQ-028 SHALL assert out_valid in HOLD, with out_data and out_flags stable until out_valid&out_ready, then return to IDLE.
REQ-029 SHALL have a fixed latency of 3 cycles from the accept edge to out_valid.
REQ-030 SHALL NOT accept a new operand until the previous result has been taken; there SHALL be no overlap.

Reset
REQ-031 SHALL, while reset=0, force state IDLE, out_valid=0, out_data=0, out_flags=0, and in_ready=0 on the first edge after release, becoming 1 in IDLE.
REQ-032 SHALL treat reset asserted mid-operation as an abort: the operand is discarded, with no out_valid pulse.

Structure
REQ-033 SHALL place the rounding-mode encodings, flag bit indices, FSM state encodings and the bias function in shared package fpu_pkg.
REQ-034 SHALL place the increment decision and significand increment in combinational sub-module fp_round_inc (inputs sign, lsb, g, s, rm; output inc), reusable by other FPU blocks.

Verification
REQ-035 SHALL cover: 0x3FF0000000000000, any rm -> 0x3F800000, flags 0, out_valid exactly 3 cycles after accept.
REQ-036 SHALL cover: 0x3FF0000010000000 (exact tie) -> RNE 0x3F800000, RUP 0x3F800001, RDN 0x3F800000; inexact=1 in all three.
REQ-037 SHALL cover: 0x47F0000000000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF; overflow=1 and inexact=1 in both. Negated input with RUP -> 0xFF7FFFFF.
REQ-038 SHALL cover: 0x7FF4000000000000 (sNaN) -> 0x7FE00000, invalid=1; 0x7FF8000000000000 -> 0x7FC00000, flags 0.
REQ-039 SHALL cover: 0x36A0000000000000 (2^-149) -> 0x00000001, flags 0; 0x3690000000000000 (2^-150) -> RNE 0x00000000, RUP 0x00000001; underflow=1 and inexact=1 in both.
REQ-040 SHALL cover: out_ready held 0 for 5 cycles -> out_data stable and in_ready=0 throughout; reset pulsed during ROUND -> no out_valid, and in_ready=1 after release.
